// File: rtl/data_cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_ctrl_pkg
// Description : Shared geometry, FSM encodings and address fields for the
//               direct-mapped write-back data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package data_cache_ctrl_pkg;

    localparam int c_ADDR_W     = 8;
    localparam int c_DATA_W     = 8;
    localparam int c_INDEX_W    = 3;
    localparam int c_OFFSET_W   = 2;
    localparam int c_TAG_W      = c_ADDR_W - c_INDEX_W - c_OFFSET_W;
    localparam int c_NUM_BLOCKS = 1 << c_INDEX_W;
    localparam int c_BLOCK_W    = c_DATA_W << c_OFFSET_W;
    localparam int c_MEM_ADDR_W = c_TAG_W + c_INDEX_W;

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WRITEBACK = 2'd1;
    localparam logic [1:0] c_MEM_RD    = 2'd2;

    typedef struct packed {
        logic [c_TAG_W-1:0]    tag;
        logic [c_INDEX_W-1:0]  index;
        logic [c_OFFSET_W-1:0] offset;
    } addr_t;

    // Byte 0 of a block sits in the least significant lane.
    function automatic logic [c_DATA_W-1:0] select_byte(
        input logic [c_BLOCK_W-1:0]  blk,
        input logic [c_OFFSET_W-1:0] off
    );
        return blk[{off, 3'b000} +: c_DATA_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_cache_ctrl_block_store.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_ctrl_block_store
// Description : Valid/dirty/tag/data arrays with a combinational read port,
//               a synchronous byte write and a synchronous block fill.
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache_ctrl_block_store
    import data_cache_ctrl_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [c_INDEX_W-1:0]  i_rd_index,
    output logic                  o_rd_valid,
    output logic                  o_rd_dirty,
    output logic [c_TAG_W-1:0]    o_rd_tag,
    output logic [c_BLOCK_W-1:0]  o_rd_block,
    input  logic                  i_wr_en,
    input  logic [c_INDEX_W-1:0]  i_wr_index,
    input  logic [c_OFFSET_W-1:0] i_wr_offset,
    input  logic [c_DATA_W-1:0]   i_wr_byte,
    input  logic                  i_fill_en,
    input  logic [c_INDEX_W-1:0]  i_fill_index,
    input  logic [c_TAG_W-1:0]    i_fill_tag,
    input  logic [c_BLOCK_W-1:0]  i_fill_block
);

    logic [c_NUM_BLOCKS-1:0] r_valid;
    logic [c_NUM_BLOCKS-1:0] r_dirty;
    logic [c_TAG_W-1:0]      r_tag  [c_NUM_BLOCKS];
    logic [c_BLOCK_W-1:0]    r_data [c_NUM_BLOCKS];

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_dirty = r_dirty[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_block = r_data[i_rd_index];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_en) begin
            r_valid[i_fill_index] <= 1'b1;
            r_dirty[i_fill_index] <= 1'b0;
        end else if (i_wr_en) begin
            r_dirty[i_wr_index] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies them.
    always_ff @(posedge CLK) begin
        if (i_fill_en) begin
            r_tag[i_fill_index]  <= i_fill_tag;
            r_data[i_fill_index] <= i_fill_block;
        end else if (i_wr_en) begin
            r_data[i_wr_index][{i_wr_offset, 3'b000} +: c_DATA_W] <= i_wr_byte;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_ctrl
// Description : Direct-mapped, write-back, write-allocate data cache between
//               the cpu load/store path and block-wide data memory.
//               Optional DCACHE_STATS_EN adds saturating hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache_ctrl
    import data_cache_ctrl_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    READ,
    input  logic                    WRITE,
    input  logic [c_ADDR_W-1:0]     ADDRESS,
    input  logic [c_DATA_W-1:0]     WRITEDATA,
    output logic [c_DATA_W-1:0]     READDATA,
    output logic                    BUSYWAIT,
    output logic                    MEM_READ,
    output logic                    MEM_WRITE,
    output logic [c_MEM_ADDR_W-1:0] MEM_ADDRESS,
    output logic [c_BLOCK_W-1:0]    MEM_WRITEDATA,
    input  logic [c_BLOCK_W-1:0]    MEM_READDATA,
    input  logic                    MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]             HIT_COUNT,
    output logic [15:0]             MISS_COUNT
`endif
);

    addr_t                  w_addr;
    logic                   w_req;
    logic                   w_idle;
    logic                   w_hit;
    logic                   w_miss_start;
    logic                   w_fill_en;
    logic                   w_wr_en;
    logic [c_INDEX_W-1:0]   w_rd_index;
    logic                   w_valid;
    logic                   w_dirty;
    logic [c_TAG_W-1:0]     w_line_tag;
    logic [c_BLOCK_W-1:0]   w_block;

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic [c_TAG_W-1:0]     r_req_tag;
    logic [c_INDEX_W-1:0]   r_req_index;

    assign w_addr = ADDRESS;
    assign w_req  = READ | WRITE;
    assign w_idle = (r_state == c_IDLE);

    // Outside IDLE the store is addressed by the latched miss, not the bus.
    assign w_rd_index = w_idle ? w_addr.index : r_req_index;

    assign w_hit        = w_idle && w_valid && (w_line_tag == w_addr.tag);
    assign w_miss_start = w_idle && w_req && !w_hit;
    assign w_wr_en      = WRITE && w_hit;
    assign w_fill_en    = (r_state == c_MEM_RD) && !MEM_BUSYWAIT;

    data_cache_ctrl_block_store u_store (
        .CLK          (CLK),
        .RESET        (RESET),
        .i_rd_index   (w_rd_index),
        .o_rd_valid   (w_valid),
        .o_rd_dirty   (w_dirty),
        .o_rd_tag     (w_line_tag),
        .o_rd_block   (w_block),
        .i_wr_en      (w_wr_en),
        .i_wr_index   (w_addr.index),
        .i_wr_offset  (w_addr.offset),
        .i_wr_byte    (WRITEDATA),
        .i_fill_en    (w_fill_en),
        .i_fill_index (r_req_index),
        .i_fill_tag   (r_req_tag),
        .i_fill_block (MEM_READDATA)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capturing the miss lets a dropped request still finish its fill.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_req_tag   <= '0;
            r_req_index <= '0;
        end else if (w_miss_start) begin
            r_req_tag   <= w_addr.tag;
            r_req_index <= w_addr.index;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_miss_start) begin
                    w_next_state = (w_valid && w_dirty) ? c_WRITEBACK : c_MEM_RD;
                end
            end
            c_WRITEBACK: begin
                if (!MEM_BUSYWAIT) begin
                    w_next_state = c_MEM_RD;
                end
            end
            c_MEM_RD: begin
                if (!MEM_BUSYWAIT) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        case (r_state)
            c_WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {w_line_tag, r_req_index};
                MEM_WRITEDATA = w_block;
            end
            c_MEM_RD: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {r_req_tag, r_req_index};
            end
            default: begin
            end
        endcase
    end

    // The stall drops with reset so the cpu is released during an abort.
    assign BUSYWAIT = RESET && w_req && !w_hit;
    assign READDATA = (READ && !WRITE && w_hit) ? select_byte(w_block, w_addr.offset) : '0;

`ifdef DCACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;
    logic        r_fill_done;

    // The hit that completes a just-filled miss belongs to that miss.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_fill_done  <= 1'b0;
        end else begin
            r_fill_done <= w_fill_en;
            if (w_req && w_hit && !r_fill_done && (r_hit_count != 16'hFFFF)) begin
                r_hit_count <= r_hit_count + 16'd1;
            end
            if (w_miss_start && (r_miss_count != 16'hFFFF)) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign HIT_COUNT  = r_hit_count;
    assign MISS_COUNT = r_miss_count;
`endif

endmodule
`default_nettype wire
